// File: rtl/tc_delay_line_prog.sv
// tc_delay_line_prog
//   Run-time programmable delay line. Each data word travels with its valid
//   bit through MAX_DEPTH physical stages. The output tap is selected
//   combinationally by 'delay'. A delay of 0 is a pure combinational bypass.
//   The line stalls when en=0, and a synchronous flush clears every stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low (clears all stages)
//   en         shift enable; 0 holds every stage
//   flush      synchronous clear of all stages; dominates en
//   delay      selected delay in clocks, 0..MAX_DEPTH (larger values clamp)
//   in_valid   qualifies in
//   in         data input
//   out_valid  valid bit at the selected tap
//   out        data at the selected tap, forced to 0 when out_valid=0
//   cfg_err    delay > MAX_DEPTH (combinational)

module tc_delay_line_prog #(
  parameter int BIT_WIDTH = 1,
  parameter int MAX_DEPTH = 4,
  localparam int DW = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic [DW-1:0]        delay,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 cfg_err
);

  localparam logic [DW-1:0] MAX_SEL = DW'(MAX_DEPTH);

  // Physical stages 1..MAX_DEPTH. Stage 0 is the live input and is not stored.
  logic [MAX_DEPTH:1]   stage_valid;
  logic [BIT_WIDTH-1:0] stage_data [1:MAX_DEPTH];

  // Tap view: index 0 is the gated input, indices 1..MAX_DEPTH are the stages.
  logic [MAX_DEPTH:0]   tap_valid;
  logic [BIT_WIDTH-1:0] tap_data [0:MAX_DEPTH];
  logic [DW-1:0]        eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        stage_data[k] <= '0;
      end
    end else if (flush) begin
      // The word presented during the flush edge is discarded along with the line.
      stage_valid <= '0;
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        stage_data[k] <= '0;
      end
    end else if (en) begin
      // Invalid words are stored as zero so that a stage never carries stale data.
      stage_valid[1] <= in_valid;
      stage_data[1]  <= in_valid ? in : '0;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
    end
  end

  assign tap_valid   = {stage_valid, in_valid};
  assign tap_data[0] = in_valid ? in : '0;

  for (genvar gi = 1; gi <= MAX_DEPTH; gi++) begin : g_tap
    assign tap_data[gi] = stage_data[gi];
  end

  // Out-of-range selections clamp to the deepest stage and raise cfg_err.
  assign cfg_err   = (delay > MAX_SEL);
  assign eff       = cfg_err ? MAX_SEL : delay;
  assign out_valid = tap_valid[eff];
  assign out       = out_valid ? tap_data[eff] : '0;

endmodule

// File: tb/tb_tc_delay_line_prog.sv
module tb_tc_delay_line_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [2:0] delay;
  logic       in_valid;
  logic [7:0] din;
  logic       out_valid;
  logic [7:0] dout;
  logic       cfg_err;

  int checks = 0;
  int failures = 0;

  tc_delay_line_prog #(.BIT_WIDTH(8), .MAX_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .delay     (delay),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       flush;
    logic [2:0] delay;
    logic       iv;
    logic [7:0] din;
    logic       ev;
    logic [7:0] eo;
    logic       ee;
  } vec_t;

  vec_t vecs [18];

  task automatic drive(input logic e, input logic f, input logic [2:0] d,
                       input logic v, input logic [7:0] x);
    en = e; flush = f; delay = d; in_valid = v; din = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic [7:0] eo, input logic ee);
    checks++;
    if (out_valid !== ev || dout !== eo || cfg_err !== ee) begin
      failures++;
      $display("FAIL %s: got valid=%b out=%02h err=%b, want valid=%b out=%02h err=%b",
               name, out_valid, dout, cfg_err, ev, eo, ee);
    end else begin
      $display("ok   %s: valid=%b out=%02h err=%b", name, out_valid, dout, cfg_err);
    end
  endtask

  // Stall sequence, delay=3: en, in_valid, in per cycle and expected tap value
  logic       st_en [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  logic       st_iv [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  logic [7:0] st_in [10] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] st_eo [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};

  initial begin
    // en fl  dly iv  in     ev  out   err     stage contents [S1..S4] at check
    vecs[0]  = '{1, 0, 3'd2, 1, 8'h11, 0, 8'h00, 0}; // all zero
    vecs[1]  = '{1, 0, 3'd2, 1, 8'h22, 0, 8'h00, 0}; // 11
    vecs[2]  = '{1, 0, 3'd2, 1, 8'h33, 1, 8'h11, 0}; // 22 11
    vecs[3]  = '{1, 0, 3'd2, 1, 8'h44, 1, 8'h22, 0}; // 33 22 11
    vecs[4]  = '{0, 0, 3'd4, 1, 8'h99, 1, 8'h11, 0}; // 44 33 22 11 (hold)
    vecs[5]  = '{0, 0, 3'd3, 0, 8'h77, 1, 8'h22, 0}; // hold
    vecs[6]  = '{0, 0, 3'd5, 0, 8'h00, 1, 8'h11, 1}; // clamp to stage 4
    vecs[7]  = '{0, 0, 3'd0, 1, 8'h5A, 1, 8'h5A, 0}; // bypass
    vecs[8]  = '{0, 0, 3'd0, 0, 8'h5A, 0, 8'h00, 0}; // bypass gated
    vecs[9]  = '{1, 0, 3'd1, 0, 8'h66, 1, 8'h44, 0}; // 44 33 22 11
    vecs[10] = '{1, 0, 3'd1, 0, 8'h00, 0, 8'h00, 0}; // -- 44 33 22
    vecs[11] = '{1, 1, 3'd4, 1, 8'h55, 1, 8'h33, 0}; // -- -- 44 33, flush
    vecs[12] = '{1, 0, 3'd4, 1, 8'h66, 0, 8'h00, 0}; // all zero
    vecs[13] = '{0, 0, 3'd1, 0, 8'h00, 1, 8'h66, 0}; // 66 (hold)
    vecs[14] = '{1, 0, 3'd7, 0, 8'h00, 0, 8'h00, 1}; // 66, clamp
    vecs[15] = '{1, 0, 3'd2, 0, 8'hAB, 1, 8'h66, 0}; // -- 66
    vecs[16] = '{0, 0, 3'd1, 0, 8'h00, 0, 8'h00, 0}; // -- -- 66
    vecs[17] = '{0, 0, 3'd3, 0, 8'h00, 1, 8'h66, 0};

    // Reset state and bypass while held in reset
    rst_n = 1'b0;
    drive(0, 0, 3'd2, 0, 8'h00);
    #3;
    chk("reset_d2", 0, 8'h00, 0);
    drive(0, 0, 3'd0, 1, 8'h3C);
    #1 chk("reset_bypass", 1, 8'h3C, 0);
    in_valid = 1'b0;
    #1 chk("reset_bypass_gated", 0, 8'h00, 0);
    tick();
    drive(1, 0, 3'd1, 1, 8'h11);
    tick();
    chk("reset_blocks_shift", 0, 8'h00, 0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].flush, vecs[i].delay, vecs[i].iv, vecs[i].din);
      #1 chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].ee);
      tick();
    end

    // Latency sweep: single word A5, visible exactly at k == delay
    for (int d = 1; d <= 4; d++) begin
      drive(1, 1, 3'(d), 0, 8'h00);
      tick();
      drive(1, 0, 3'(d), 1, 8'hA5);
      #1 chk($sformatf("sweep_d%0d_pre", d), 0, 8'h00, 0);
      tick();
      drive(1, 0, 3'(d), 0, 8'h00);
      for (int k = 1; k <= 6; k++) begin
        #1 chk($sformatf("sweep_d%0d_k%0d", d, k), (k == d), (k == d) ? 8'hA5 : 8'h00, 0);
        tick();
      end
    end

    // Stall: delay=3, words 1..4, en low for 2 cycles after word 2
    drive(1, 1, 3'd3, 0, 8'h00);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(st_en[c], 0, 3'd3, st_iv[c], st_in[c]);
      #1 chk($sformatf("stall_c%0d", c), (st_eo[c] != 8'h00), st_eo[c], 0);
      tick();
    end

    // Flush: fill with 11..44, flush while 55 is presented
    drive(1, 1, 3'd4, 0, 8'h00);
    tick();
    for (int w = 1; w <= 4; w++) begin
      drive(1, 0, 3'd4, 1, 8'(w * 8'h11));
      tick();
    end
    drive(1, 1, 3'd4, 1, 8'h55);
    #1 chk("flush_before", 1, 8'h11, 0);
    tick();
    drive(1, 0, 3'd4, 0, 8'h00);
    for (int d = 1; d <= 4; d++) begin
      delay = 3'(d);
      #1 chk($sformatf("flush_tap%0d", d), 0, 8'h00, 0);
    end
    drive(1, 0, 3'd4, 1, 8'h66);
    #1 chk("flush_accept", 0, 8'h00, 0);
    tick();
    drive(1, 0, 3'd4, 0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("flush_after_k%0d", k), (k == 4), (k == 4) ? 8'h66 : 8'h00, 0);
      tick();
    end

    // Config: clamp and mid-stream delay change
    drive(1, 1, 3'd4, 0, 8'h00);
    tick();
    for (int w = 1; w <= 4; w++) begin
      drive(1, 0, 3'd4, 1, 8'hC0 + 8'(w));
      tick();
    end
    drive(1, 0, 3'd4, 1, 8'hC5);
    #1 chk("cfg_d4", 1, 8'hC1, 0);
    delay = 3'd5;
    #1 chk("cfg_d5_clamp", 1, 8'hC1, 1);
    tick();
    drive(0, 0, 3'd1, 0, 8'h00);
    #1 chk("cfg_4to1_newest", 1, 8'hC5, 0);
    delay = 3'd5;
    #1 chk("cfg_d5_next", 1, 8'hC2, 1);
    delay = 3'd2;
    #1 chk("cfg_d2", 1, 8'hC4, 0);

    // Asynchronous mid-cycle reset, reset dominating flush, then release
    rst_n = 1'b0;
    #1 chk("async_reset", 0, 8'h00, 0);
    drive(1, 1, 3'd2, 1, 8'h77);
    tick();
    chk("reset_with_flush", 0, 8'h00, 0);
    rst_n = 1'b1;
    drive(1, 0, 3'd2, 1, 8'h77);
    #1 chk("release_no_effect", 0, 8'h00, 0);
    tick();
    drive(1, 0, 3'd2, 0, 8'h00);
    #1 chk("post_reset_k1", 0, 8'h00, 0);
    tick();
    chk("post_reset_k2", 1, 8'h77, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
